// File: rtl/ld_st_if.sv
// Request/status bundle between a requester (master) and ld_st_unit (slave).
interface ld_st_if #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned REG_BITS = 5
);
    logic                start;
    logic [1:0]          op;
    logic [REG_BITS-1:0] ra;
    logic [REG_BITS-1:0] rb;
    logic [REG_BITS-1:0] rw;
    logic [WIDTH-1:0]    imm;
    logic [REG_BITS-1:0] dbg_ra;
    logic                busy;
    logic                done;
    logic                err;
    logic [WIDTH-1:0]    dbg_data;

    modport master (
        output start, op, ra, rb, rw, imm, dbg_ra,
        input  busy, done, err, dbg_data
    );

    modport slave (
        input  start, op, ra, rb, rw, imm, dbg_ra,
        output busy, done, err, dbg_data
    );
endinterface

// File: rtl/ld_st_unit.sv
// Sequential load/store/load-immediate unit: register file plus word memory,
// one request at a time through ADDR -> MEM -> WB.
module ld_st_unit #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned REG_BITS  = 5,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic   clk,
    input  logic   reset,
    ld_st_if.slave bus
);
    localparam int unsigned NUM_REGS  = 2 ** REG_BITS;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LI    = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_WB} state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]           op_q;
    logic [REG_BITS-1:0]  ra_q;
    logic [REG_BITS-1:0]  rb_q;
    logic [REG_BITS-1:0]  rw_q;
    logic [WIDTH-1:0]     imm_q;

    logic [WIDTH-1:0]     regs [NUM_REGS];
    logic [WIDTH-1:0]     mem  [MEM_DEPTH];

    logic [WIDTH-1:0]     base_c;
    logic [WIDTH-1:0]     src_c;
    logic [WIDTH-1:0]     ea_c;
    logic                 range_err_c;

    logic [ADDR_BITS-1:0] ea_idx_q;
    logic [WIDTH-1:0]     st_data_q;
    logic                 err_int_q;
    logic [WIDTH-1:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_MEM;
            S_MEM:  state_nxt = S_WB;
            S_WB:   state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = (state != S_IDLE);

    // Request fields are captured only on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rw_q  <= '0;
            imm_q <= '0;
        end else if (state == S_IDLE && bus.start) begin
            op_q  <= bus.op;
            ra_q  <= bus.ra;
            rb_q  <= bus.rb;
            rw_q  <= bus.rw;
            imm_q <= bus.imm;
        end
    end

    // Register 0 is never written, and reads of it are forced to zero as well.
    always_comb begin
        base_c      = (ra_q == '0) ? '0 : regs[ra_q];
        src_c       = (rb_q == '0) ? '0 : regs[rb_q];
        ea_c        = base_c + imm_q;
        range_err_c = ((ea_c >> ADDR_BITS) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ea_idx_q  <= '0;
            st_data_q <= '0;
            err_int_q <= 1'b0;
        end else if (state == S_ADDR) begin
            ea_idx_q  <= ea_c[ADDR_BITS-1:0];
            st_data_q <= src_c;
            err_int_q <= (op_q == OP_RSVD) ||
                         (((op_q == OP_LOAD) || (op_q == OP_STORE)) && range_err_c);
        end
    end

    // Memory has no reset; a reset edge still blocks a pending store.
    always_ff @(posedge clk) begin
        if (!reset && state == S_MEM) begin
            if (op_q == OP_STORE && !err_int_q) mem[ea_idx_q] <= st_data_q;
            rdata_q <= mem[ea_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else if (state == S_WB && !err_int_q && rw_q != '0) begin
            if (op_q == OP_LOAD)    regs[rw_q] <= rdata_q;
            else if (op_q == OP_LI) regs[rw_q] <= imm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.done <= (state == S_WB);
            bus.err  <= (state == S_WB) && err_int_q;
        end
    end

    assign bus.dbg_data = (bus.dbg_ra == '0) ? '0 : regs[bus.dbg_ra];
endmodule

// File: doc/ld_st_unit.md
LD_ST_UNIT -- requirements
Module: ld_st_unit

Interface
REQ-001 Parameter WIDTH, default 64: data, register and immediate width in bits.
REQ-002 Parameter REG_BITS, default 5: register index width; register count = 2**REG_BITS.
REQ-003 Parameter ADDR_BITS, default 8: memory index width; memory depth = 2**ADDR_BITS words of WIDTH bits.
REQ-004 Port list is as follows; one clock, and reset is synchronous and active-high.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 load, 01 store, 10 load-immediate, 11 reserved.
- ra  input  REG_BITS  base-address register.
- rb  input  REG_BITS  store-data source register.
- rw  input  REG_BITS  load destination register.
- imm  input  WIDTH  address offset (load/store) or value (load-immediate).
- dbg_ra  input  REG_BITS  debug read index.
- busy  output  1  high while a request is in flight.
- done  output  1  one-cycle completion pulse.
- err  output  1  error status of the request completing with done.
- dbg_data  output  WIDTH  combinational register read: reg[dbg_ra].

Function
REQ-005 The FSM SHALL have four states, IDLE, ADDR, MEM and WB, with transitions IDLE->ADDR on start, then ADDR->MEM->WB->IDLE unconditionally.
REQ-006 When start is high in IDLE, the block SHALL latch op, ra, rb, rw and imm at that edge; later input changes SHALL NOT affect the request.
REQ-007 While the FSM is not in IDLE, start SHALL be ignored (no queueing), and busy SHALL be high (state != IDLE).
REQ-008 In ADDR, the block SHALL register ea = reg[ra] + imm (mod 2**WIDTH), register reg[rb], and set err_int = 1 when ea >= 2**ADDR_BITS or op == 11.
REQ-009 In MEM, a store without error SHALL write mem[ea[ADDR_BITS-1:0]] = latched reg[rb], and a load SHALL register mem[ea] (synchronous read).
REQ-010 In WB, a load without error SHALL write the read data to reg[rw], and a load-immediate SHALL write imm to reg[rw]; load-immediate never sets err.
REQ-011 Register 0 SHALL always read as zero; writes to it are discarded without error.
REQ-012 A request with err_int set SHALL perform no memory and no register write.
REQ-013 done SHALL be registered and high for exactly the one cycle after WB (4 cycles after the start edge), with err valid in that same cycle and 0 otherwise.
REQ-014 A start asserted in the cycle where done is high SHALL be accepted, because the FSM is then in IDLE (back-to-back throughput of 1 request per 4 cycles).
REQ-015 The address add SHALL wrap modulo 2**WIDTH; wrapped results below 2**ADDR_BITS SHALL be treated as valid addresses.
REQ-016 A store followed by a load to the same address SHALL return the stored value, since requests are strictly sequential.

Reset
REQ-017 When reset is high at a clock edge, the block SHALL set the FSM to IDLE, busy = 0, done = 0, err = 0, and all registers to 0.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reset mid-request SHALL abort the request with no done pulse, and any write not yet performed SHALL be suppressed.
REQ-020 Reset SHALL take priority over start in the same cycle.

Verification
REQ-021 LI r1 = 5; LI r2 = 0xABCD; store (ra=1, rb=2, imm=3); load (ra=1, rw=4, imm=3) -> dbg reg4 = 0xABCD, and each done occurs 4 cycles after its start with err = 0.
REQ-022 LI r1 = 2**ADDR_BITS - 1; store with imm=1 -> err = 1 with done, and the memory is unchanged (a load at address 0 returns its prior value).
REQ-023 LI r1 = all-ones; load with imm=2 -> ea wraps to 1, err = 0, and rw receives mem[1].
REQ-024 LI to r0 with imm=7 -> dbg r0 = 0; op=11 -> err = 1 and no state change.
REQ-025 Start held high continuously -> one request accepted per 4 cycles, and the start pulses seen while busy are ignored.
REQ-026 Reset asserted during MEM of a store -> busy = 0 and no done next cycle; the target memory word is unchanged; all registers read 0.
